// File: rtl/maze_pkg.sv
// maze_pkg: shared maze encodings, grid defaults and solver state enum.
package maze_pkg;
    localparam int GRID_W = 16;
    localparam int GRID_H = 16;
    localparam logic [1:0] HDG_N = 2'd0;
    localparam logic [1:0] HDG_E = 2'd1;
    localparam logic [1:0] HDG_S = 2'd2;
    localparam logic [1:0] HDG_W = 2'd3;
    localparam logic PATH = 1'b1;
    localparam logic WALL = 1'b0;
    typedef enum logic [1:0] {S_IDLE, S_WALK, S_DONE, S_FAIL} state_t;
endpackage

// File: rtl/maze_neighbor_probe.sv
// maze_neighbor_probe: picks the right-hand-rule move from the current cell, off-grid cells read as wall.
module maze_neighbor_probe #(
    parameter int GRID_W = maze_pkg::GRID_W,
    parameter int GRID_H = maze_pkg::GRID_H,
    parameter int XW = $clog2(GRID_W),
    parameter int YW = $clog2(GRID_H)
) (
    input  logic [GRID_W*GRID_H-1:0] snap,
    input  logic [XW-1:0]            pos_x,
    input  logic [YW-1:0]            pos_y,
    input  logic [1:0]               heading,
    output logic [1:0]               dir,
    output logic [XW-1:0]            next_x,
    output logic [YW-1:0]            next_y,
    output logic                     any_open
);
    import maze_pkg::*;
    localparam logic [XW:0] ONE_X = 1;
    localparam logic [YW:0] ONE_Y = 1;
    logic [XW:0] cx [4];
    logic [YW:0] cy [4];
    logic [3:0] is_open;
    logic [1:0] c_r, c_l;
    // The extra top bit turns -1 and GRID_W into out-of-range values.
    always_comb begin
        cx[HDG_N] = {1'b0, pos_x};
        cy[HDG_N] = {1'b0, pos_y} - ONE_Y;
        cx[HDG_E] = {1'b0, pos_x} + ONE_X;
        cy[HDG_E] = {1'b0, pos_y};
        cx[HDG_S] = {1'b0, pos_x};
        cy[HDG_S] = {1'b0, pos_y} + ONE_Y;
        cx[HDG_W] = {1'b0, pos_x} - ONE_X;
        cy[HDG_W] = {1'b0, pos_y};
        for (int d = 0; d < 4; d++)
            is_open[d] = cx[d] < (XW+1)'(GRID_W) && cy[d] < (YW+1)'(GRID_H)
                         && snap[{cy[d][YW-1:0], cx[d][XW-1:0]}] == PATH;
    end
    assign c_r = heading + 2'd1;
    assign c_l = heading - 2'd1;
    assign dir = is_open[c_r] ? c_r : is_open[heading] ? heading : is_open[c_l] ? c_l : heading + 2'd2;
    assign any_open = |is_open;
    assign next_x = cx[dir][XW-1:0];
    assign next_y = cy[dir][YW-1:0];
endmodule

// File: rtl/maze_wall_follower.sv
// maze_wall_follower: snapshots a carved maze and walks it from (0,0) to the goal with the right-hand rule.
module maze_wall_follower #(
    parameter int GRID_W = maze_pkg::GRID_W,
    parameter int GRID_H = maze_pkg::GRID_H,
    parameter int MAX_STEPS = 1023,
    parameter int CNT_W = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         maze_ready,
    input  logic [GRID_W*GRID_H-1:0]     maze_data,
    input  logic [$clog2(GRID_W)-1:0]    goal_x,
    input  logic [$clog2(GRID_H)-1:0]    goal_y,
    input  logic                         step_en,
    output logic                         busy,
    output logic [$clog2(GRID_W)-1:0]    pos_x,
    output logic [$clog2(GRID_H)-1:0]    pos_y,
    output logic [1:0]                   heading,
    output logic                         step_valid,
    output logic [CNT_W-1:0]             step_count,
    output logic                         done,
    output logic                         fail
);
    import maze_pkg::*;
    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);
    state_t state, state_nxt;
    logic [GRID_W*GRID_H-1:0] snap;
    logic [XW-1:0] gx, nx;
    logic [YW-1:0] gy, ny;
    logic [1:0] dir;
    logic any_open, accept, at_goal, at_max, move;

    maze_neighbor_probe #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_probe (
        .snap(snap), .pos_x(pos_x), .pos_y(pos_y), .heading(heading),
        .dir(dir), .next_x(nx), .next_y(ny), .any_open(any_open)
    );

    assign accept = start && maze_ready && state != S_WALK;
    assign at_goal = pos_x == gx && pos_y == gy;
    assign at_max = step_count == CNT_W'(MAX_STEPS);
    assign move = state == S_WALK && step_en && !at_goal && !at_max && any_open;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state != S_WALK ? (accept ? (maze_data[0] == PATH ? S_WALK : S_FAIL) : state)
                  : !step_en ? S_WALK
                  : at_goal ? S_DONE
                  : (at_max || !any_open) ? S_FAIL : S_WALK;
    end

    always_comb begin
        busy = state == S_WALK;
        done = state == S_DONE;
        fail = state == S_FAIL;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            snap <= '0;
            gx <= '0;
            gy <= '0;
            pos_x <= '0;
            pos_y <= '0;
            heading <= HDG_E;
            step_count <= '0;
            step_valid <= 1'b0;
        end else begin
            step_valid <= move;
            if (accept) begin
                snap <= maze_data;
                gx <= goal_x;
                gy <= goal_y;
                pos_x <= '0;
                pos_y <= '0;
                heading <= HDG_E;
                step_count <= '0;
            end else if (move) begin
                pos_x <= nx;
                pos_y <= ny;
                heading <= dir;
                step_count <= step_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_maze_wall_follower.sv
// tb_maze_wall_follower: directed scenarios plus random mazes checked against a plain right-hand-rule walker.
module tb_maze_wall_follower;
    localparam int MAX_STEPS = 20;
    logic clk = 1'b0;
    logic rst_n, start, maze_ready, step_en;
    logic [255:0] maze_data;
    logic [3:0] goal_x, goal_y;
    logic busy, step_valid, done, fail;
    logic [3:0] pos_x, pos_y;
    logic [1:0] heading;
    logic [9:0] step_count;
    logic [255:0] corridor = 256'hFFFF;
    int total = 0, bad = 0;
    int qx[$], qy[$], qh[$];
    int exp_res, exp_steps;

    maze_wall_follower #(.GRID_W(16), .GRID_H(16), .MAX_STEPS(MAX_STEPS), .CNT_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .maze_ready(maze_ready),
        .maze_data(maze_data), .goal_x(goal_x), .goal_y(goal_y), .step_en(step_en),
        .busy(busy), .pos_x(pos_x), .pos_y(pos_y), .heading(heading),
        .step_valid(step_valid), .step_count(step_count), .done(done), .fail(fail)
    );

    always #5 clk = ~clk;

    // Reference walker: exp_res 1 = reaches goal, 2 = fails; queues hold every move.
    task automatic model(input logic [255:0] m, input int gx, input int gy);
        int dx[4] = '{0, 1, 0, -1};
        int dy[4] = '{-1, 0, 1, 0};
        int ord[4] = '{1, 0, 3, 2};
        int x = 0, y = 0, h = 1, n = 0, d, nx, ny;
        bit moved;
        qx.delete(); qy.delete(); qh.delete();
        exp_res = 2;
        exp_steps = 0;
        if (!m[0]) return;
        forever begin
            if (x == gx && y == gy) begin exp_res = 1; break; end
            if (n == MAX_STEPS) break;
            moved = 0;
            for (int k = 0; k < 4 && !moved; k++) begin
                d = (h + ord[k]) % 4;
                nx = x + dx[d];
                ny = y + dy[d];
                if (nx >= 0 && nx < 16 && ny >= 0 && ny < 16 && m[ny*16+nx]) begin
                    x = nx; y = ny; h = d; n++; moved = 1;
                    qx.push_back(x); qy.push_back(y); qh.push_back(h);
                end
            end
            if (!moved) break;
        end
        exp_steps = n;
    endtask

    // Presents a start for one edge, then scrambles maze/goal so the snapshot is what counts.
    task automatic start_walk(input logic [255:0] m, input logic [3:0] gx, input logic [3:0] gy);
        maze_data = m; goal_x = gx; goal_y = gy; maze_ready = 1; start = 1;
        @(negedge clk);
        start = 0; maze_data = ~m; goal_x = ~gx; goal_y = ~gy;
    endtask

    task automatic test_reset;
        logic [25:0] got, exp;
        rst_n = 0; start = 0; maze_ready = 0; step_en = 0; maze_data = '0; goal_x = 0; goal_y = 0;
        repeat (2) @(negedge clk);
        total++;
        got = {busy, step_valid, done, fail, pos_x, pos_y, heading, step_count};
        exp = {4'b0000, 4'd0, 4'd0, 2'd1, 10'd0};
        if (got !== exp) begin bad++; $display("FAIL reset: got %h want %h", got, exp); end
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_corridor;
        logic [21:0] got, exp;
        logic [13:0] got_t, exp_t;
        step_en = 1;
        start_walk(corridor, 4'd15, 4'd0);
        total++;
        got = {busy, step_valid, pos_x, pos_y, heading, step_count};
        exp = {1'b1, 1'b0, 4'd0, 4'd0, 2'd1, 10'd0};
        if (got !== exp) begin bad++; $display("FAIL corridor start: got %h want %h", got, exp); end
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            total++;
            got = {busy, step_valid, pos_x, pos_y, heading, step_count};
            exp = {1'b1, 1'b1, 4'(i), 4'd0, 2'd1, 10'(i)};
            if (got !== exp) begin bad++; $display("FAIL corridor step %0d: got %h want %h", i, got, exp); end
        end
        @(negedge clk);
        total++;
        got_t = {done, fail, busy, step_valid, step_count};
        exp_t = {4'b1000, 10'd15};
        if (got_t !== exp_t) begin bad++; $display("FAIL corridor end: got %h want %h", got_t, exp_t); end
    endtask

    task automatic test_dead_end;
        logic [255:0] m = '0;
        int rx[5] = '{0, 1, 2, 1, 1};
        int ry[5] = '{1, 1, 1, 1, 0};
        int rh[5] = '{2, 1, 1, 3, 0};
        logic [21:0] got, exp;
        logic [13:0] got_t, exp_t;
        m[0] = 1; m[1] = 1; m[16] = 1; m[17] = 1; m[18] = 1;
        step_en = 1;
        start_walk(m, 4'd1, 4'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            got = {busy, step_valid, pos_x, pos_y, heading, step_count};
            exp = {1'b1, 1'b1, 4'(rx[i]), 4'(ry[i]), 2'(rh[i]), 10'(i + 1)};
            if (got !== exp) begin bad++; $display("FAIL dead_end step %0d: got %h want %h", i + 1, got, exp); end
        end
        @(negedge clk);
        total++;
        got_t = {done, fail, busy, step_valid, step_count};
        exp_t = {4'b1000, 10'd5};
        if (got_t !== exp_t) begin bad++; $display("FAIL dead_end end: got %h want %h", got_t, exp_t); end
    endtask

    task automatic test_budget;
        logic [16:0] got, exp;
        step_en = 1;
        start_walk(corridor, 4'd5, 4'd5);
        for (int i = 1; i <= MAX_STEPS; i++) begin
            @(negedge clk);
            total++;
            if (step_count !== 10'(i)) begin bad++; $display("FAIL budget count: got %0d want %0d", step_count, i); end
        end
        @(negedge clk);
        total++;
        got = {done, fail, busy, step_count, pos_x};
        exp = {1'b0, 1'b1, 1'b0, 10'd20, 4'd10};
        if (got !== exp) begin bad++; $display("FAIL budget end: got %h want %h", got, exp); end
    endtask

    task automatic test_closed_start;
        logic [12:0] got, exp;
        step_en = 1;
        start_walk(~256'h1, 4'd3, 4'd0);
        total++;
        got = {busy, done, fail, step_count};
        exp = {3'b001, 10'd0};
        if (got !== exp) begin bad++; $display("FAIL closed_start: got %h want %h", got, exp); end
        maze_ready = 0; start = 1; maze_data = corridor; goal_x = 15; goal_y = 0;
        repeat (3) @(negedge clk);
        total++;
        got = {busy, done, fail, step_count};
        if (got !== exp) begin bad++; $display("FAIL not_ready: got %h want %h", got, exp); end
        start = 0; maze_ready = 1;
    endtask

    task automatic test_step_en;
        logic pat[4] = '{1, 0, 0, 1};
        logic [14:0] got, exp;
        int n = 0;
        start_walk(corridor, 4'd15, 4'd0);
        for (int i = 0; i < 4; i++) begin
            step_en = pat[i];
            @(negedge clk);
            n += int'(pat[i]);
            total++;
            got = {step_valid, pos_x, step_count};
            exp = {pat[i], 4'(n), 10'(n)};
            if (got !== exp) begin bad++; $display("FAIL step_en cycle %0d: got %h want %h", i, got, exp); end
        end
        step_en = 1;
        for (int c = 0; c < 40 && busy; c++) @(negedge clk);
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL step_en drain: got done=%b want 1", done); end
    endtask

    task automatic test_reset_mid_walk;
        logic [25:0] got, exp;
        step_en = 1;
        start_walk(corridor, 4'd15, 4'd0);
        repeat (5) @(negedge clk);
        total++;
        if (pos_x !== 4'd5) begin bad++; $display("FAIL mid_walk pos: got %0d want 5", pos_x); end
        rst_n = 0;
        @(negedge clk);
        total++;
        got = {busy, step_valid, done, fail, pos_x, pos_y, heading, step_count};
        exp = {4'b0000, 4'd0, 4'd0, 2'd1, 10'd0};
        if (got !== exp) begin bad++; $display("FAIL mid_walk reset: got %h want %h", got, exp); end
        rst_n = 1;
        test_corridor();
    endtask

    task automatic test_random;
        logic [255:0] m;
        logic [3:0] gx, gy;
        logic [21:0] got, exp;
        logic [12:0] got_t, exp_t;
        int idx, ex, ey, eh;
        bit en, sv, walking;
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < 256; i++) m[i] = ($urandom % 100) < 65;
            m[0] = ($urandom % 8) != 0;
            gx = 4'($urandom % 6);
            gy = 4'($urandom % 6);
            model(m, int'(gx), int'(gy));
            start_walk(m, gx, gy);
            total++;
            got = {busy, step_valid, pos_x, pos_y, heading, step_count};
            exp = {m[0], 1'b0, 4'd0, 4'd0, 2'd1, 10'd0};
            if (got !== exp) begin bad++; $display("FAIL random %0d start: got %h want %h", it, got, exp); end
            idx = 0;
            walking = m[0];
            for (int c = 0; c < 300 && busy; c++) begin
                en = 1'($urandom % 2);
                step_en = en;
                start = 1'($urandom % 2);
                @(negedge clk);
                sv = 0;
                if (en) begin
                    if (idx < qx.size()) begin idx++; sv = 1; end
                    else walking = 0;
                end
                ex = idx == 0 ? 0 : qx[idx-1];
                ey = idx == 0 ? 0 : qy[idx-1];
                eh = idx == 0 ? 1 : qh[idx-1];
                total++;
                got = {busy, step_valid, pos_x, pos_y, heading, step_count};
                exp = {walking, sv, 4'(ex), 4'(ey), 2'(eh), 10'(idx)};
                if (got !== exp) begin bad++; $display("FAIL random %0d cycle %0d: got %h want %h", it, c, got, exp); end
            end
            start = 0;
            total++;
            got_t = {busy, done, fail, step_count};
            exp_t = {1'b0, exp_res == 1, exp_res == 2, 10'(exp_steps)};
            if (got_t !== exp_t) begin bad++; $display("FAIL random %0d end: got %h want %h", it, got_t, exp_t); end
        end
    endtask

    initial begin
        test_reset();
        test_corridor();
        test_dead_end();
        test_budget();
        test_closed_start();
        test_step_en();
        test_reset_mid_walk();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
